// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 load/store byte-lane path.
// Holds the access-size encoding used on st_sel (and the load byte unit),
// the beat state encoding, and small helpers for size decode.
package rv32_mem_pkg;

    typedef enum logic [2:0] {
        SZ_W = 3'd0,
        SZ_H = 3'd1,
        SZ_B = 3'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    // Byte mask for an access size, right-justified. Illegal sizes give 0,
    // so nothing downstream can enable a lane for them.
    function automatic logic [3:0] size_mask(input logic [2:0] sel);
        logic [3:0] m;
        case (sel)
            SZ_W:    m = 4'b1111;
            SZ_H:    m = 4'b0011;
            SZ_B:    m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic size_legal(input logic [2:0] sel);
        return (sel == SZ_W) || (sel == SZ_H) || (sel == SZ_B);
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane aligner for stores.
// Ports:
//   i_data  [31:0] store operand, right-justified
//   i_off   [1:0]  byte offset within the word
//   i_size  [2:0]  access size (SZ_W/SZ_H/SZ_B)
//   i_beat         0 = first word, 1 = spill into the next word
//   o_wdata [31:0] lane-aligned data for the selected beat (disabled lanes 0)
//   o_be    [3:0]  byte enables for the selected beat
//   o_split        access crosses a word boundary
module store_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_beat,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_split
);

    logic [3:0]  w_mask;
    logic [31:0] w_data_masked;
    logic [7:0]  w_be_wide;
    logic [63:0] w_data_wide;

    // Shifting into a double-width window puts beat 0 in the low half and
    // the spill-over beat in the high half, so both beats share one shifter.
    always_comb begin
        w_mask        = size_mask(i_size);
        w_data_masked = i_data & {{8{w_mask[3]}}, {8{w_mask[2]}},
                                  {8{w_mask[1]}}, {8{w_mask[0]}}};
        w_be_wide     = {4'b0000, w_mask} << i_off;
        w_data_wide   = {32'h0, w_data_masked} << {i_off, 3'b000};
        o_split       = |w_be_wide[7:4];
        if (i_beat) begin
            o_be    = w_be_wide[7:4];
            o_wdata = w_data_wide[63:32];
        end else begin
            o_be    = w_be_wide[3:0];
            o_wdata = w_data_wide[31:0];
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store from the pipeline, aligns it to byte lanes
// and issues one or two word-aligned write beats to memory.
//
//   state | meaning
//   IDLE  | ready for a new request
//   BEAT0 | first (or only) word beat outstanding
//   BEAT1 | spill-over beat into the next word outstanding
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   st_valid/st_ready           request handshake
//   st_addr, st_data, st_sel    byte address, right-justified data, size
//   mem_req/mem_gnt             write beat handshake
//   mem_addr, mem_wdata, mem_be word address, lane data, byte enables
//   st_done                     pulse after the final beat is granted
//   st_err                      pulse after an illegal size is accepted
module store_unit
    import rv32_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic [2:0]              st_sel,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    st_done,
    output logic                    st_err
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [2:0]            r_sel;
    logic                  r_done;
    logic                  r_err;

    state_e                w_state_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH/8-1:0] w_be;
    logic                  w_split;

    store_align u_align (
        .i_data  (r_data),
        .i_off   (r_addr[1:0]),
        .i_size  (r_sel),
        .i_beat  (r_state == BEAT1),
        .o_wdata (w_wdata),
        .o_be    (w_be),
        .o_split (w_split)
    );

    assign w_accept = st_valid && st_ready;
    assign w_base   = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_addr <= st_addr;
                r_data <= st_data;
                r_sel  <= st_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        st_ready    = 1'b0;
        mem_req     = 1'b0;
        case (r_state)
            IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    if (size_legal(st_sel)) begin
                        w_state_nxt = BEAT0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            BEAT0: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (w_split) begin
                        w_state_nxt = BEAT1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs are decoded from registered state only, so they
    // hold steady across a stalled beat and drop to zero the moment reset
    // asserts.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            mem_addr  = (r_state == BEAT1) ? (w_base + ADDR_WIDTH'(4)) : w_base;
            mem_wdata = w_wdata;
            mem_be    = w_be;
        end
    end

    assign st_done = r_done;
    assign st_err  = r_err;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_sel;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        st_done;
    logic        st_err;

    logic gnt_rand;
    logic gnt_dir;
    logic gnt_rnd;

    int checks;
    int failures;

    beat_t exp_q[$];
    int    evt_q[$];   // 0 = st_done expected, 1 = st_err expected

    store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_sel    (st_sel),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .st_done   (st_done),
        .st_err    (st_err)
    );

    assign mem_gnt = gnt_rand ? gnt_rnd : gnt_dir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        gnt_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            gnt_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = d;
        exp_q.push_back(b);
    endtask

    // Reference: walk the bytes of the store one at a time at their absolute
    // (wrapping) addresses and group consecutive bytes by containing word.
    task automatic model_push(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel);
        int    nb;
        beat_t b;
        bit    have;
        logic [31:0] a;
        logic [31:0] w;
        int    lane;
        if (sel > 3'd2) begin
            evt_q.push_back(1);
            return;
        end
        nb   = (sel == 3'd0) ? 4 : ((sel == 3'd1) ? 2 : 1);
        have = 0;
        b.addr = '0; b.be = '0; b.wdata = '0;
        for (int k = 0; k < nb; k++) begin
            a    = addr + 32'(k);
            w    = {a[31:2], 2'b00};
            lane = int'(a[1:0]);
            if (!have) begin
                b.addr = w; b.be = '0; b.wdata = '0; have = 1;
            end else if (w != b.addr) begin
                exp_q.push_back(b);
                b.addr = w; b.be = '0; b.wdata = '0;
            end
            b.be[lane] = 1'b1;
            b.wdata[8*lane +: 8] = data[8*k +: 8];
        end
        exp_q.push_back(b);
        evt_q.push_back(0);
    endtask

    // Waits for st_ready, presents one request for exactly one accepting edge,
    // returns 1 time unit after that edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s, input bit use_model);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!st_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'(st_ready), 32'd1);
        st_addr  = a;
        st_data  = d;
        st_sel   = s;
        st_valid = 1'b1;
        if (use_model) model_push(a, d, s);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_addr  = $urandom;
        st_data  = $urandom;
        st_sel   = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || evt_q.size() != 0 || !st_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 32'(exp_q.size() + evt_q.size()), 32'd0);
    endtask

    // Monitor: compares every granted beat and every done/err pulse against
    // the scoreboard, and checks outputs hold across a stalled beat.
    initial begin
        beat_t e;
        beat_t prev;
        int    ev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev.addr = '0; prev.be = '0; prev.wdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && prev_stall) begin
                check("stall_addr",  mem_addr,        prev.addr);
                check("stall_be",    32'(mem_be),     32'(prev.be));
                check("stall_wdata", mem_wdata,       prev.wdata);
            end
            if (mem_req && mem_gnt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", mem_addr, 32'hx);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr",  mem_addr,    e.addr);
                    check("beat_be",    32'(mem_be), 32'(e.be));
                    check("beat_wdata", mem_wdata,   e.wdata);
                end
            end
            if (st_done || st_err) begin
                if (evt_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, st_err, st_done}, 32'd0);
                end else begin
                    ev = evt_q.pop_front();
                    check("pulse_done", 32'(st_done), (ev == 0) ? 32'd1 : 32'd0);
                    check("pulse_err",  32'(st_err),  (ev == 1) ? 32'd1 : 32'd0);
                end
            end
            prev_stall = mem_req && !mem_gnt;
            prev.addr  = mem_addr;
            prev.be    = mem_be;
            prev.wdata = mem_wdata;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  s;
        logic [31:0] a;
        checks   = 0;
        failures = 0;
        gnt_rand = 1'b0;
        gnt_dir  = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_sel   = '0;
        rst_n    = 1'b0;
        #1;
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_req",   32'(mem_req),  32'd0);
        check("rst_be",    32'(mem_be),   32'd0);
        check("rst_addr",  mem_addr,      32'd0);
        check("rst_wdata", mem_wdata,     32'd0);
        check("rst_done",  32'(st_done),  32'd0);
        check("rst_err",   32'(st_err),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, expectations taken literally.
        gnt_dir = 1'b1;
        push_beat(32'h0000_1000, 4'b1000, 32'hDD00_0000);
        evt_q.push_back(0);
        send(32'h0000_1003, 32'hAABB_CCDD, 3'd2, 0);
        wait_drain();

        push_beat(32'h0000_2000, 4'b1100, 32'h1234_0000);
        evt_q.push_back(0);
        send(32'h0000_2002, 32'h0000_1234, 3'd1, 0);
        wait_drain();

        push_beat(32'h0000_3000, 4'b1110, 32'h2233_4400);
        push_beat(32'h0000_3004, 4'b0001, 32'h0000_0011);
        evt_q.push_back(0);
        send(32'h0000_3001, 32'h1122_3344, 3'd0, 0);
        wait_drain();

        push_beat(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        push_beat(32'h0000_0000, 4'b0001, 32'h0000_00BE);
        evt_q.push_back(0);
        send(32'hFFFF_FFFF, 32'h0000_BEEF, 3'd1, 0);
        wait_drain();

        // Illegal size.
        evt_q.push_back(1);
        send(32'h0000_0040, 32'h1234_5678, 3'd3, 0);
        check("illegal_err",   32'(st_err),   32'd1);
        check("illegal_req",   32'(mem_req),  32'd0);
        check("illegal_ready", 32'(st_ready), 32'd1);
        @(posedge clk);
        #1;
        check("illegal_err_once", 32'(st_err),  32'd0);
        check("illegal_no_done",  32'(st_done), 32'd0);
        check("illegal_no_req",   32'(mem_req), 32'd0);
        wait_drain();

        // Aligned latency with grant held high.
        push_beat(32'h0000_0100, 4'b1111, 32'hCAFE_F00D);
        evt_q.push_back(0);
        send(32'h0000_0100, 32'hCAFE_F00D, 3'd0, 0);
        check("lat_req_t1",   32'(mem_req),  32'd1);
        check("lat_ready_t1", 32'(st_ready), 32'd0);
        @(posedge clk);
        #1;
        check("lat_done_t2",  32'(st_done),  32'd1);
        check("lat_ready_t2", 32'(st_ready), 32'd1);
        check("lat_req_t2",   32'(mem_req),  32'd0);
        wait_drain();

        // Stalled split store, then reset in the second beat.
        gnt_dir = 1'b0;
        push_beat(32'h0000_0000, 4'b1100, 32'hC3D4_0000);
        send(32'h0000_0002, 32'hA1B2_C3D4, 3'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        gnt_dir = 1'b1;
        @(posedge clk);
        #1;
        gnt_dir = 1'b0;
        check("beat1_addr", mem_addr,    32'h0000_0004);
        check("beat1_be",   32'(mem_be), 32'h3);
        check("beat1_wdata", mem_wdata,  32'h0000_A1B2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_req",   32'(mem_req),  32'd0);
        check("rstmid_ready", 32'(st_ready), 32'd1);
        check("rstmid_be",    32'(mem_be),   32'd0);
        check("rstmid_addr",  mem_addr,      32'd0);
        check("rstmid_wdata", mem_wdata,     32'd0);
        @(posedge clk);
        #1;
        check("rstmid_no_done", 32'(st_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_no_done2", 32'(st_done), 32'd0);
        check("rstmid_ready2",   32'(st_ready), 32'd1);
        check("rstmid_q_empty",  32'(exp_q.size() + evt_q.size()), 32'd0);

        // Randomized traffic against the byte-walk model.
        gnt_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            send(a, $urandom, s, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_drain();
        check("final_beats_empty",  32'(exp_q.size()), 32'd0);
        check("final_events_empty", 32'(evt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; clock and reset are the first two ports, as below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 st_valid  in  1  store request valid from the pipeline.
REQ-007 st_ready  out  1  unit can accept a request.
REQ-008 st_addr  in  ADDR_WIDTH  byte address of the store.
REQ-009 st_data  in  DATA_WIDTH  store operand, right-justified.
REQ-010 st_sel  in  3  size: 0 = SW, 1 = SH, 2 = SB; 3..7 are illegal (same encoding as the load byte unit).
REQ-011 mem_req  out  1  memory write request.
REQ-012 mem_gnt  in  1  memory accepts the current beat.
REQ-013 mem_addr  out  ADDR_WIDTH  word-aligned beat address; bits [1:0] = 0.
REQ-014 mem_wdata  out  DATA_WIDTH  lane-aligned write data.
REQ-015 mem_be  out  DATA_WIDTH/8  byte enables; bit i = byte lane i.
REQ-016 st_done  out  1  one-cycle pulse when the store has fully completed.
REQ-017 st_err  out  1  one-cycle pulse when an illegal st_sel is accepted.

Function
REQ-018 SHALL implement the FSM states IDLE, BEAT0, BEAT1; st_ready = 1 only in IDLE.
REQ-019 A request SHALL be accepted when st_valid && st_ready; st_addr, st_data and st_sel are registered on that edge.
REQ-020 For a legal accept, the FSM SHALL go IDLE->BEAT0; mem_req = 1 in BEAT0 and BEAT1 only.
REQ-021 Each beat SHALL complete on the edge where mem_req && mem_gnt is true.
REQ-022 mem_addr, mem_wdata and mem_be SHALL hold stable while mem_req && !mem_gnt.
REQ-023 Beat-0 definitions:
  - off = addr[1:0]; mask = 0xF (SW), 0x3 (SH), 0x1 (SB).
  - Beat-0 mem_be = (mask << off) truncated to 4 bits.
  - Beat-0 mem_wdata = st_data << 8*off.
  - Beat-0 mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-024 The store is split when (mask << off) exceeds 4 bits: SW with off != 0, or SH with off = 3.
REQ-025 On grant of a split store's beat 0, the FSM SHALL go BEAT0->BEAT1, with:
  - mem_be = mask >> (4 - off);
  - mem_wdata = st_data >> 8*(4 - off);
  - mem_addr = beat-0 address + 4, wrapping modulo 2^ADDR_WIDTH.
REQ-026 On grant of the final beat, the FSM SHALL return to IDLE and st_done SHALL pulse high for exactly the following cycle.
REQ-027 Latency: an aligned store with mem_gnt held high SHALL be accepted at T, drive mem_req at T+1, pulse st_done at T+2, and raise st_ready at T+2.
REQ-028 For an illegal st_sel, no mem_req SHALL be issued; st_err SHALL pulse for the cycle after accept, the FSM stays in IDLE, and st_done stays 0.
REQ-029 mem_wdata bits in disabled lanes SHALL be 0.

Reset
REQ-030 While rst_n = 0, the unit SHALL immediately hold:
  - state = IDLE, st_ready = 1;
  - mem_req = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0;
  - st_done = 0, st_err = 0.
REQ-031 Reset during BEAT0 or BEAT1 SHALL abandon the store, with no st_done; any byte already granted remains written in memory.

Structure
REQ-032 Package rv32_mem_pkg SHALL hold the size enum (SZ_W = 0, SZ_H = 1, SZ_B = 2) and the state enum shared with the load path.
REQ-033 Sub-module store_align SHALL be purely combinational: (data, off, size, beat) -> (wdata, be, split).

Verification
REQ-034 SB at 0x1003, data 0xAABBCCDD -> one beat: addr 0x1000, be 1000, wdata 0xDD000000; st_done once.
REQ-035 SH at 0x2002, data 0x00001234 -> one beat: addr 0x2000, be 1100, wdata 0x12340000.
REQ-036 SW at 0x3001, data 0x11223344 -> two beats:
  - beat 0: addr 0x3000, be 1110, wdata 0x22334400;
  - beat 1: addr 0x3004, be 0001, wdata 0x00000011.
REQ-037 SH at 0xFFFFFFFF, data 0xBEEF -> two beats:
  - beat 0: addr 0xFFFFFFFC, be 1000, wdata 0xEF000000;
  - beat 1: addr 0x00000000, be 0001, wdata 0x000000BE.
REQ-038 st_sel = 3 -> no mem_req; st_err high for 1 cycle; st_ready high the next cycle.
REQ-039 SW at 0x0002 with mem_gnt low for 3 cycles -> outputs stable throughout; rst_n dropped during BEAT1 -> mem_req = 0 immediately, no st_done, st_ready = 1.
